nios_cpu_mul_seq: RTL

Multi-cycle 32x32 multiply sequencer for the Nios CPU custom-multiply path. Owns one registered 16x16 unsigned multiplier cell and issues the four half-word partial products through it over successive cycles. Accumulates the partial products into a 64-bit sum, then applies the signed correction to the high word. Returns the low word (mul) or the high word (mulxss/mulxsu/mulxuu) over a valid/ready handshake.

---
 rtl/nios_cpu_mul_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nios_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer: four 16x16 partial products through one
// registered multiplier cell, then signed high-word correction. Optional: NIOS_MUL_SEQ_ZERO_SKIP_EN.
module nios_cpu_mul_seq #(
   parameter int MULT_PIPE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_src1,
   input  logic [31:0] in_src2,
   input  logic [1:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_CORR, S_DONE} state_t;

   localparam logic [1:0] DRAIN_LAST = 2'(MULT_PIPE - 1);

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [1:0]  op_q, op_d, k_q, k_d, cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_result_q, out_result_d;

   logic [31:0] pp_q [MULT_PIPE];
   logic [31:0] pp_d [MULT_PIPE];
   logic [1:0]  pk_q [MULT_PIPE];
   logic [1:0]  pk_d [MULT_PIPE];
   logic        pv_q [MULT_PIPE];
   logic        pv_d [MULT_PIPE];

   logic        issue, last_issue, zero_op;
   logic [15:0] mul_a, mul_b;
   logic [63:0] addend;
   logic [31:0] hi;

   assign in_ready   = (state_q == S_IDLE) & ~reset;
   assign busy       = (state_q != S_IDLE);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      k_d          = k_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;

      // Partial-product index k selects the half-words: k[1] picks A's half, k[0] picks B's.
      issue      = (state_q == S_ISSUE);
      last_issue = (op_q == 2'b00) ? (k_q == 2'd2) : (k_q == 2'd3);
      mul_a      = k_q[1] ? a_q[31:16] : a_q[15:0];
      mul_b      = k_q[0] ? b_q[31:16] : b_q[15:0];

      pp_d[0] = issue ? ({16'b0, mul_a} * {16'b0, mul_b}) : pp_q[0];
      pk_d[0] = issue ? k_q : pk_q[0];
      pv_d[0] = issue;
      for (int i = 1; i < MULT_PIPE; i++) begin
         pp_d[i] = pp_q[i-1];
         pk_d[i] = pk_q[i-1];
         pv_d[i] = pv_q[i-1];
      end

      case (pk_q[MULT_PIPE-1])
         2'd0:    addend = {32'b0, pp_q[MULT_PIPE-1]};
         2'd3:    addend = {pp_q[MULT_PIPE-1], 32'b0};
         default: addend = {16'b0, pp_q[MULT_PIPE-1], 16'b0};
      endcase
      if (pv_q[MULT_PIPE-1]) acc_d = acc_q + addend;

      // Unsigned-to-signed correction of the high word.
      hi = acc_q[63:32];
      if (((op_q == 2'b01) || (op_q == 2'b10)) && a_q[31]) hi = hi - b_q;
      if ((op_q == 2'b01) && b_q[31]) hi = hi - a_q;

`ifdef NIOS_MUL_SEQ_ZERO_SKIP_EN
      zero_op = (in_src1 == 32'b0) || (in_src2 == 32'b0);
`else
      zero_op = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = in_src1;
               b_d     = in_src2;
               op_d    = in_op;
               acc_d   = 64'b0;
               k_d     = 2'd0;
               // A zero operand yields a zero accumulator, so CORR produces 0 directly.
               state_d = zero_op ? S_CORR : S_ISSUE;
            end
         end
         S_ISSUE: begin
            k_d = k_q + 2'd1;
            if (last_issue) begin
               state_d = S_DRAIN;
               cnt_d   = 2'd0;
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) state_d = S_CORR;
            else                     cnt_d   = cnt_q + 2'd1;
         end
         S_CORR: begin
            out_result_d = (op_q == 2'b00) ? acc_q[31:0] : hi;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         k_q          <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         for (int i = 0; i < MULT_PIPE; i++) begin
            pp_q[i] <= '0;
            pk_q[i] <= '0;
            pv_q[i] <= 1'b0;
         end
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         k_q          <= k_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         for (int i = 0; i < MULT_PIPE; i++) begin
            pp_q[i] <= pp_d[i];
            pk_q[i] <= pk_d[i];
            pv_q[i] <= pv_d[i];
         end
      end
   end

endmodule
